alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_pkg.sv | 51 +++++
 rtl/alu_seq_ctrl_if.sv | 28 ++
 rtl/alu_seq_regfile.sv | 35 +++
 rtl/alu_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared types, field offsets and defaults for the ALU sequencer
package alu_seq_ctrl_pkg;

  localparam int W_DEF    = 8;
  localparam int NREG_DEF = 8;
  localparam int INSTR_W  = 9;
  localparam int REG_AW   = 3;
  localparam int OP_LSB   = 6;
  localparam int RA_LSB   = 3;
  localparam int RB_LSB   = 0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SRL  = 3'b001,
    ALU_NOR  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_CLR  = 3'b101,
    ALU_RSV6 = 3'b110,
    ALU_RSV7 = 3'b111
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  function automatic alu_cmd_e instr_op(input logic [INSTR_W-1:0] i);
    return alu_cmd_e'(i[OP_LSB +: 3]);
  endfunction

  function automatic logic [REG_AW-1:0] instr_ra(input logic [INSTR_W-1:0] i);
    return i[RA_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rb(input logic [INSTR_W-1:0] i);
    return i[RB_LSB +: REG_AW];
  endfunction

  // SUB is compare-only and the reserved ops never touch the register file
  function automatic logic op_writes_reg(input alu_cmd_e op);
    return (op == ALU_ADD) || (op == ALU_SRL) || (op == ALU_NOR) ||
           (op == ALU_AND) || (op == ALU_CLR);
  endfunction

  function automatic logic op_is_reserved(input alu_cmd_e op);
    return (op == ALU_RSV6) || (op == ALU_RSV7);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - instruction handshake, ALU port and retire signals
interface alu_seq_ctrl_if
  import alu_seq_ctrl_pkg::*;
#(
  parameter int W = W_DEF
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [2:0]         alu_cmd;
  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [W-1:0]       alu_rslt;
  logic               alu_zero;
  logic               done;
  logic               branch_taken;

  // master: instruction source plus the external ALU; slave: the sequencer
  modport master (
    output instr_valid, instr, alu_rslt, alu_zero,
    input  instr_ready, alu_cmd, alu_a, alu_b, done, branch_taken
  );

  modport slave (
    input  instr_valid, instr, alu_rslt, alu_zero,
    output instr_ready, alu_cmd, alu_a, alu_b, done, branch_taken
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - NREG x W register file, one sync write port, three async read ports
module alu_seq_regfile
  import alu_seq_ctrl_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] raddr_d,
  output logic [W-1:0]      rdata_a,
  output logic [W-1:0]      rdata_b,
  output logic [W-1:0]      rdata_d
);
  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];
endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - three-state issue/writeback sequencer for an external ALU; ALU_SEQ_ILLEGAL_TRAP_EN enables the reserved-op trap
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  alu_seq_ctrl_if.slave     bus,
  input  logic              dbg_we,
  input  logic [REG_AW-1:0] dbg_addr,
  input  logic [W-1:0]      dbg_wdata,
  output logic [W-1:0]      dbg_rdata,
  output logic              trap
);
  state_e             state;
  logic [INSTR_W-1:0] instr_q;
  logic [W-1:0]       rslt_q;
  logic               trap_q;
  alu_cmd_e           op_q;
  logic [REG_AW-1:0]  ra_q;
  logic [REG_AW-1:0]  rb_q;
  logic [W-1:0]       rd_a;
  logic [W-1:0]       rd_b;
  logic               handshake;
  logic               rf_we;
  logic [REG_AW-1:0]  rf_waddr;
  logic [W-1:0]       rf_wdata;

  assign op_q = instr_op(instr_q);
  assign ra_q = instr_ra(instr_q);
  assign rb_q = instr_rb(instr_q);

  assign bus.instr_ready = (state == ST_IDLE) && !trap_q;
  assign handshake       = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      instr_q          <= '0;
      rslt_q           <= '0;
      bus.done         <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.alu_cmd      <= ALU_CLR;
    end else begin
      bus.done         <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.alu_cmd      <= ALU_CLR;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            instr_q     <= bus.instr;
            bus.alu_cmd <= instr_op(bus.instr);
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // done/branch_taken are raised here so they are high for exactly the WB cycle
          rslt_q           <= bus.alu_rslt;
          bus.done         <= 1'b1;
          bus.branch_taken <= (op_q == ALU_SUB) && bus.alu_zero;
          state            <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (state == ST_WB && op_is_reserved(op_q)) begin
      trap_q <= 1'b1;
    end
  end
`else
  assign trap_q = 1'b0;
`endif

  assign trap = trap_q;

  assign bus.alu_a = (state == ST_ISSUE) ? rd_a : '0;
  assign bus.alu_b = (state == ST_ISSUE) ? rd_b : '0;

  // WB and debug writes never coincide: debug is only honoured in IDLE
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = dbg_addr;
    rf_wdata = dbg_wdata;
    if (state == ST_WB) begin
      rf_we    = op_writes_reg(op_q);
      rf_waddr = ra_q;
      rf_wdata = rslt_q;
    end else if (state == ST_IDLE) begin
      rf_we    = dbg_we;
    end
  end

  alu_seq_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (ra_q),
    .raddr_b (rb_q),
    .raddr_d (dbg_addr),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .rdata_d (dbg_rdata)
  );
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized self-checking bench for alu_seq_ctrl against a register-file model
module tb_alu_seq_ctrl;
  logic       clk;
  logic       reset;
  logic       dbg_we;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic [7:0] dbg_rdata;
  logic       trap;

  int n_checks;
  int n_fail;

  logic [7:0] model [8];

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  alu_seq_ctrl_if #(.W(8)) bus ();

  alu_seq_ctrl #(.W(8), .NREG(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .trap      (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a >> b[2:0];
      3'b010:  return ~(a | b);
      3'b011:  return a & b;
      3'b100:  return a - b;
      default: return 8'h00;
    endcase
  endfunction

  // stand-in for the external combinational ALU
  assign bus.alu_rslt = ref_alu(bus.alu_cmd, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_rslt == 8'h00);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    dbg_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  task automatic dbg_write(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    dbg_we = 1'b1;
    dbg_addr = addr;
    dbg_wdata = data;
    @(posedge clk);
    #1;
    dbg_we = 1'b0;
    model[addr] = data;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb);
    logic [7:0] a, b, r;
    bit exp_br, exp_trap;
    @(negedge clk);
    a = model[ra];
    b = model[rb];
    r = ref_alu(op, a, b);
    exp_br = (op == 3'b100) && (r == 8'h00);
    exp_trap = TRAP_EN && (op >= 3'b110);
    n_checks++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before op=%0d: got %b want 1", op, bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr = {op, ra, rb};
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = 9'($urandom);
    @(negedge clk);
    n_checks++;
    if (bus.alu_cmd !== op || bus.alu_a !== a || bus.alu_b !== b || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL issue op=%0d: got cmd=%0d a=%h b=%h done=%b want cmd=%0d a=%h b=%h done=0",
               op, bus.alu_cmd, bus.alu_a, bus.alu_b, bus.done, op, a, b);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.branch_taken !== exp_br || bus.alu_cmd !== 3'b101 || bus.alu_a !== 8'h00) begin
      n_fail++;
      $display("FAIL wb op=%0d: got done=%b br=%b cmd=%0d a=%h want done=1 br=%b cmd=5 a=00",
               op, bus.done, bus.branch_taken, bus.alu_cmd, bus.alu_a, exp_br);
    end
    if (op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101}) model[ra] = r;
    @(negedge clk);
    dbg_addr = ra;
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.instr_ready !== !exp_trap || trap !== exp_trap || dbg_rdata !== model[ra]) begin
      n_fail++;
      $display("FAIL retire op=%0d: got done=%b ready=%b trap=%b r%0d=%h want done=0 ready=%b trap=%b r%0d=%h",
               op, bus.done, bus.instr_ready, trap, ra, dbg_rdata, !exp_trap, exp_trap, ra, model[ra]);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      n_checks++;
      if (dbg_rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg r%0d: got %h want 00", i, dbg_rdata);
      end
    end
    n_checks++;
    if (bus.alu_cmd !== 3'b101 || bus.instr_ready !== 1'b1 || bus.done !== 1'b0 ||
        bus.branch_taken !== 1'b0 || trap !== 1'b0 || bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd=%0d ready=%b done=%b br=%b trap=%b a=%h b=%h want 5 1 0 0 0 00 00",
               bus.alu_cmd, bus.instr_ready, bus.done, bus.branch_taken, trap, bus.alu_a, bus.alu_b);
    end
  endtask

  task automatic test_add();
    dbg_write(3'd1, 8'h05);
    dbg_write(3'd2, 8'h03);
    run_instr(3'b000, 3'd1, 3'd2);
    dbg_addr = 3'd1;
    #1;
    n_checks++;
    if (dbg_rdata !== 8'h08) begin
      n_fail++;
      $display("FAIL add_r1: got %h want 08", dbg_rdata);
    end
  endtask

  task automatic test_sub_branch();
    dbg_write(3'd3, 8'h7A);
    dbg_write(3'd4, 8'h7A);
    run_instr(3'b100, 3'd3, 3'd4);
    dbg_write(3'd4, 8'h10);
    run_instr(3'b100, 3'd3, 3'd4);
    dbg_addr = 3'd3;
    #1;
    n_checks++;
    if (dbg_rdata !== 8'h7A) begin
      n_fail++;
      $display("FAIL sub_r3_kept: got %h want 7a", dbg_rdata);
    end
    run_instr(3'b000, 3'd6, 3'd6);
  endtask

  task automatic test_dbg();
    logic [7:0] x, a, r, keep7;
    @(negedge clk);
    x = 8'($urandom);
    dbg_we = 1'b1;
    dbg_addr = 3'd2;
    dbg_wdata = x;
    bus.instr_valid = 1'b1;
    bus.instr = {3'b000, 3'd1, 3'd2};
    @(posedge clk);
    #1;
    dbg_we = 1'b0;
    bus.instr_valid = 1'b0;
    model[2] = x;
    a = model[1];
    r = ref_alu(3'b000, a, x);
    keep7 = model[7];
    @(negedge clk);
    n_checks++;
    if (bus.alu_a !== a || bus.alu_b !== x) begin
      n_fail++;
      $display("FAIL dbg_same_cycle: got a=%h b=%h want a=%h b=%h", bus.alu_a, bus.alu_b, a, x);
    end
    dbg_we = 1'b1;
    dbg_addr = 3'd7;
    dbg_wdata = ~keep7;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL dbg_done: got %b want 1", bus.done);
    end
    @(negedge clk);
    dbg_we = 1'b0;
    model[1] = r;
    #1;
    n_checks++;
    if (dbg_rdata !== keep7) begin
      n_fail++;
      $display("FAIL dbg_ignored_busy r7: got %h want %h", dbg_rdata, keep7);
    end
    dbg_addr = 3'd1;
    #1;
    n_checks++;
    if (dbg_rdata !== r) begin
      n_fail++;
      $display("FAIL dbg_result r1: got %h want %h", dbg_rdata, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op, ra, rb;
    logic [7:0] a, b, r;
    int n_done;
    n_done = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      op = 3'($urandom_range(0, 5));
      ra = 3'($urandom);
      rb = 3'($urandom);
      a = model[ra];
      b = model[rb];
      r = ref_alu(op, a, b);
      bus.instr_valid = 1'b1;
      bus.instr = {op, ra, rb};
      n_checks++;
      if (bus.instr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready k=%0d: got %b want 1", k, bus.instr_ready);
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      n_checks++;
      if (bus.alu_cmd !== op || bus.alu_a !== a || bus.alu_b !== b || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_issue k=%0d: got cmd=%0d a=%h b=%h done=%b want %0d %h %h 0",
                 k, bus.alu_cmd, bus.alu_a, bus.alu_b, bus.done, op, a, b);
      end
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      n_checks++;
      if (bus.done !== 1'b1 || bus.alu_cmd !== 3'b101 || bus.instr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_wb k=%0d: got done=%b cmd=%0d ready=%b want 1 5 0", k, bus.done, bus.alu_cmd, bus.instr_ready);
      end
      if (op != 3'b100) model[ra] = r;
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      n_checks++;
      if (bus.alu_cmd !== 3'b101 || bus.alu_a !== 8'h00) begin
        n_fail++;
        $display("FAIL b2b_idle k=%0d: got cmd=%0d a=%h want 5 00", k, bus.alu_cmd, bus.alu_a);
      end
    end
    bus.instr_valid = 1'b0;
    n_checks++;
    if (n_done != 4) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d want 4", n_done);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      n_checks++;
      if (dbg_rdata !== model[i]) begin
        n_fail++;
        $display("FAIL b2b_reg r%0d: got %h want %h", i, dbg_rdata, model[i]);
      end
    end
  endtask

  task automatic test_reset_in_issue();
    dbg_write(3'd5, 8'hFF);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = {3'b101, 3'd5, 3'd0};
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.alu_cmd !== 3'b101 || bus.alu_a !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_issue_pre: got cmd=%0d a=%h want 5 ff", bus.alu_cmd, bus.alu_a);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    @(negedge clk);
    dbg_addr = 3'd5;
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1 || bus.alu_cmd !== 3'b101 || dbg_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_issue_post: got done=%b ready=%b cmd=%0d r5=%h want 0 1 5 00",
               bus.done, bus.instr_ready, bus.alu_cmd, dbg_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_issue_nodone: got %b want 0", bus.done);
    end
  endtask

  task automatic test_illegal();
    dbg_write(3'd2, 8'h33);
    dbg_write(3'd3, 8'h44);
    run_instr(3'b110, 3'd2, 3'd3);
    if (TRAP_EN) begin
      bus.instr_valid = 1'b1;
      bus.instr = {3'b000, 3'd2, 3'd3};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        n_checks++;
        if (bus.instr_ready !== 1'b0 || bus.done !== 1'b0 || trap !== 1'b1) begin
          n_fail++;
          $display("FAIL trap_hold: got ready=%b done=%b trap=%b want 0 0 1", bus.instr_ready, bus.done, trap);
        end
      end
      reset_dut();
      n_checks++;
      if (trap !== 1'b0 || bus.instr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL trap_cleared: got trap=%b ready=%b want 0 1", trap, bus.instr_ready);
      end
    end else begin
      run_instr(3'b111, 3'd2, 3'd3);
      run_instr(3'b000, 3'd2, 3'd3);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) dbg_write(3'($urandom), 8'($urandom));
      run_instr(TRAP_EN ? 3'($urandom_range(0, 5)) : 3'($urandom), 3'($urandom), 3'($urandom));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    dbg_we = 1'b0;
    dbg_addr = 3'd0;
    dbg_wdata = 8'h00;
    bus.instr_valid = 1'b0;
    bus.instr = 9'h000;
    test_reset();
    test_add();
    test_sub_branch();
    test_dbg();
    test_back_to_back();
    test_reset_in_issue();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
